// File: rtl/stepper_pkg.sv
// Shared types and widths for the dual-axis step/direction pulse sequencer.
// STEP_POSITION_TRACK_EN enables the per-axis position accumulators.
package stepper_pkg;

    localparam int unsigned STEP_W = 9;
    localparam int unsigned POS_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIR_SETUP,
        ST_PULSE_HIGH,
        ST_PULSE_LOW,
        ST_DONE
    } state_e;

    // Per-axis command latched on a load
    typedef struct packed {
        logic              dir;
        logic [STEP_W-1:0] steps;
    } axis_cmd_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/step_axis_counter.sv
// One stepper axis: remaining-step counter, step pulse gating and latched direction.
// STEP_POSITION_TRACK_EN adds a saturating signed position accumulator.
module step_axis_counter
    import stepper_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  axis_cmd_t               cmd,
    input  logic                    fire,
    input  logic                    hold,
    output logic                    step,
    output logic                    dir,
`ifdef STEP_POSITION_TRACK_EN
    output logic signed [POS_W-1:0] pos,
`endif
    output logic                    pending_c
);

    logic [STEP_W-1:0] remaining;
    logic              take;

    // A slot only consumes a step when this axis still has one left
    assign take      = fire && (remaining != '0);
    assign pending_c = (remaining != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
        end else begin
            if (load) begin
                remaining <= cmd.steps;
                dir       <= cmd.dir;
            end else if (take) begin
                remaining <= remaining - STEP_W'(1);
            end

            if (fire) begin
                step <= take;
            end else if (!hold) begin
                step <= 1'b0;
            end
        end
    end

`ifdef STEP_POSITION_TRACK_EN
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    // Position persists across moves and saturates symmetrically
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (take) begin
            if (dir && (pos != POS_MAX)) begin
                pos <= pos + POS_ONE;
            end else if (!dir && (pos != POS_MIN)) begin
                pos <= pos - POS_ONE;
            end
        end
    end
`endif

endmodule

// File: rtl/stepper_pulse_sequencer.sv
// Dual-axis step/direction sequencer: latches step counts on dataReady and emits
// slot-aligned step pulses. STEP_POSITION_TRACK_EN adds pos1/pos2 outputs.
module stepper_pulse_sequencer
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_PERIOD      = 50000,
    parameter int unsigned PULSE_WIDTH      = 100,
    parameter int unsigned DIR_SETUP_CYCLES = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [STEP_W-1:0]       steps1,
    input  logic [STEP_W-1:0]       steps2,
    input  logic                    dir1,
    input  logic                    dir2,
    input  logic                    dataReady,
    output logic                    step1,
    output logic                    step2,
    output logic                    dirOut1,
    output logic                    dirOut2,
`ifdef STEP_POSITION_TRACK_EN
    output logic signed [POS_W-1:0] pos1,
    output logic signed [POS_W-1:0] pos2,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int unsigned TMR_MAX = max3(STEP_PERIOD, PULSE_WIDTH, DIR_SETUP_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_HIGH  = TMR_W'(PULSE_WIDTH - 1);
    localparam logic [TMR_W-1:0] TMR_LOW   = TMR_W'(STEP_PERIOD - PULSE_WIDTH - 1);

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              load_c, fire_c, hold_c;
    logic              pending1_c, pending2_c, any_pending_c;
    axis_cmd_t         cmd1, cmd2;

    assign cmd1          = '{dir: dir1, steps: steps1};
    assign cmd2          = '{dir: dir2, steps: steps2};
    assign any_pending_c = pending1_c || pending2_c;

    // State, shared slot timer and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);
            if (load_c) begin
                overrun <= 1'b0;
            end else if (dataReady && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Next state, timer reload and per-slot strobes to the axes
    always_comb begin
        state_d = state_q;
        tmr_d   = (tmr_q == '0) ? '0 : tmr_q - TMR_W'(1);
        load_c  = 1'b0;
        fire_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dataReady) begin
                    load_c  = 1'b1;
                    state_d = ST_DIR_SETUP;
                    tmr_d   = TMR_SETUP;
                end
            end
            ST_DIR_SETUP, ST_PULSE_LOW: begin
                if (tmr_q == '0) begin
                    if (any_pending_c) begin
                        fire_c  = 1'b1;
                        state_d = ST_PULSE_HIGH;
                        tmr_d   = TMR_HIGH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PULSE_HIGH: begin
                if (tmr_q == '0) begin
                    state_d = ST_PULSE_LOW;
                    tmr_d   = TMR_LOW;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hold_c = (state_d == ST_PULSE_HIGH);

    step_axis_counter u_axis1 (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load_c),
        .cmd       (cmd1),
        .fire      (fire_c),
        .hold      (hold_c),
        .step      (step1),
        .dir       (dirOut1),
`ifdef STEP_POSITION_TRACK_EN
        .pos       (pos1),
`endif
        .pending_c (pending1_c)
    );

    step_axis_counter u_axis2 (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load_c),
        .cmd       (cmd2),
        .fire      (fire_c),
        .hold      (hold_c),
        .step      (step2),
        .dir       (dirOut2),
`ifdef STEP_POSITION_TRACK_EN
        .pos       (pos2),
`endif
        .pending_c (pending2_c)
    );

endmodule

// File: tb/tb_stepper_pulse_sequencer.sv
// Scoreboard bench for stepper_pulse_sequencer: moves push expected step/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_stepper_pulse_sequencer;

    localparam int unsigned SP = 8;
    localparam int unsigned PW = 2;
    localparam int unsigned DS = 4;
    localparam int          BUDGET = 6000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dataReady = 1'b0;
    logic        dir1 = 1'b0;
    logic        dir2 = 1'b0;
    logic [8:0]  steps1 = '0;
    logic [8:0]  steps2 = '0;
    logic        step1, step2, dirOut1, dirOut2, busy, done, overrun;
`ifdef STEP_POSITION_TRACK_EN
    logic signed [15:0] pos1, pos2;
`endif

    stepper_pulse_sequencer #(
        .STEP_PERIOD      (SP),
        .PULSE_WIDTH      (PW),
        .DIR_SETUP_CYCLES (DS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .steps1    (steps1),
        .steps2    (steps2),
        .dir1      (dir1),
        .dir2      (dir2),
        .dataReady (dataReady),
        .step1     (step1),
        .step2     (step2),
        .dirOut1   (dirOut1),
        .dirOut2   (dirOut2),
`ifdef STEP_POSITION_TRACK_EN
        .pos1      (pos1),
        .pos2      (pos2),
`endif
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { int cyc; logic dir; } step_exp_t;
    typedef struct packed { int cyc; logic d1; logic d2; logic ovr; } done_exp_t;

    step_exp_t q1[$];
    step_exp_t q2[$];
    done_exp_t qd[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected events for a move loaded at edge e0
    task automatic push_move(input int e0, input int s1, input logic d1,
                             input int s2, input logic d2, input logic ovr);
        int n;
        for (int i = 0; i < s1; i++) q1.push_back('{cyc: e0 + DS + SP * i, dir: d1});
        for (int i = 0; i < s2; i++) q2.push_back('{cyc: e0 + DS + SP * i, dir: d2});
        n = (s1 > s2) ? s1 : s2;
        qd.push_back('{cyc: e0 + DS + SP * n, d1: d1, d2: d2, ovr: ovr});
    endtask

    int         rise_c[2];
    logic [1:0] prev_s = '0;
    logic [1:0] wv = '0;
    logic       busy_next_chk = 1'b0;

    task automatic mon_axis(input int ax, input logic s, input logic d);
        step_exp_t e;
        int        qs;
        qs = (ax == 0) ? q1.size() : q2.size();
        if (s && !prev_s[ax]) begin
            rise_c[ax] = cyc;
            if (qs == 0) begin
                n_cmp++;
                n_err++;
                wv[ax] = 1'b0;
                $display("FAIL step%0d_unexpected: rise at cycle %0d, none expected", ax + 1, cyc);
            end else begin
                if (ax == 0) e = q1.pop_front();
                else         e = q2.pop_front();
                chk($sformatf("step%0d_rise_cycle", ax + 1), cyc, e.cyc);
                chk($sformatf("dirOut%0d_at_step", ax + 1), int'(d), int'(e.dir));
                wv[ax] = 1'b1;
            end
        end else if (!s && prev_s[ax] && wv[ax]) begin
            chk($sformatf("step%0d_width", ax + 1), cyc - rise_c[ax], PW);
            wv[ax] = 1'b0;
        end
        prev_s[ax] = s;
    endtask

    // Monitor: compares DUT events against the scoreboard queues
    always @(negedge clk) begin
        done_exp_t de;
        if (!reset) begin
            prev_s        = '0;
            wv            = '0;
            busy_next_chk = 1'b0;
        end else begin
            mon_axis(0, step1, dirOut1);
            mon_axis(1, step2, dirOut2);
            if (busy_next_chk) begin
                chk("busy_after_done", int'(busy), 0);
                busy_next_chk = 1'b0;
            end
            if (done) begin
                if (qd.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    de = qd.pop_front();
                    chk("done_cycle", cyc, de.cyc);
                    chk("done_dirOut1", int'(dirOut1), int'(de.d1));
                    chk("done_dirOut2", int'(dirOut2), int'(de.d2));
                    chk("done_overrun", int'(overrun), int'(de.ovr));
                    chk("busy_during_done", int'(busy), 1);
                end
                busy_next_chk = 1'b1;
            end
        end
    end

    task automatic load(input int s1, input logic d1, input int s2, input logic d2,
                        input logic ovr, output int e0);
        @(negedge clk);
        steps1    = 9'(s1);
        steps2    = 9'(s2);
        dir1      = d1;
        dir2      = d2;
        dataReady = 1'b1;
        e0        = cyc + 1;
        push_move(e0, s1, d1, s2, d2, ovr);
        @(negedge clk);
        dataReady = 1'b0;
        chk("busy_at_load", int'(busy), 1);
        chk("dirOut1_at_load", int'(dirOut1), int'(d1));
        chk("dirOut2_at_load", int'(dirOut2), int'(d2));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((qd.size() != 0 || busy) && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= BUDGET) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
        end
        chk({name, "_leftover_steps"}, q1.size() + q2.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int e0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step1", int'(step1), 0);
        chk("rst_step2", int'(step2), 0);
        chk("rst_dirOut1", int'(dirOut1), 0);
        chk("rst_dirOut2", int'(dirOut2), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b1;
        @(negedge clk);

        load(3, 1'b1, 1, 1'b0, 1'b0, e0);
        wait_done("basic");

        load(0, 1'b1, 0, 1'b1, 1'b0, e0);
        wait_done("zero");

        // Strobe at E0+10 with different inputs must be dropped
        load(3, 1'b0, 2, 1'b1, 1'b1, e0);
        repeat (9) @(negedge clk);
        steps1    = 9'd7;
        dataReady = 1'b1;
        @(negedge clk);
        dataReady = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        wait_done("overrun");
        chk("overrun_sticky", int'(overrun), 1);
        load(0, 1'b0, 0, 1'b0, 1'b0, e0);
        chk("overrun_cleared", int'(overrun), 0);
        wait_done("clear");

        // Reset lands inside the first step pulse
        load(3, 1'b1, 2, 1'b1, 1'b0, e0);
        repeat (5) @(posedge clk);
        #1;
        chk("step1_before_reset", int'(step1), 1);
        reset = 1'b0;
        #1;
        chk("midrst_step1", int'(step1), 0);
        chk("midrst_step2", int'(step2), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_dirOut1", int'(dirOut1), 0);
        chk("midrst_dirOut2", int'(dirOut2), 0);
        q1.delete();
        q2.delete();
        qd.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        load(2, 1'b0, 0, 1'b1, 1'b0, e0);
        wait_done("after_reset");

        load(511, 1'b1, 0, 1'b0, 1'b0, e0);
        wait_done("max");

`ifdef STEP_POSITION_TRACK_EN
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        load(5, 1'b1, 0, 1'b0, 1'b0, e0);
        wait_done("pos_fwd");
        chk("pos1_after_fwd", int'(pos1), 5);
        load(7, 1'b0, 0, 1'b0, 1'b0, e0);
        wait_done("pos_rev");
        chk("pos1_after_rev", int'(pos1), -2);
        chk("pos2_untouched", int'(pos2), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
